// File: rtl/game_state_ctl.sv
// Scene sequencer: IDLE -> WAITING -> GAME -> SCORE, with a frame-aligned scene select and a UART "ready" request.
// Latency: a click or uart_start moves state 2 cycles after the input rises; game_over moves it 1 cycle later; scene_sel follows on the next frame tick.
// Backpressure: uart_tx_req is held until uart_tx_ack is sampled high; no other input can stall the block.
// Optional: define GAME_AUTO_RESTART_EN so that SCORE expiry re-enters WAITING, and a stop edge in SCORE returns to IDLE.
module game_state_ctl #(
  parameter int WAIT_TIMEOUT_FRAMES = 255,
  parameter int SCORE_FRAMES        = 180,
  parameter int FRAME_CNT_W         = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       rect_clicked_play,
  input  logic       mouse_clicked_stop,
  input  logic       uart_start,
  input  logic       game_over,
  input  logic       uart_tx_ack,
  output logic       uart_tx_req,
  output logic [1:0] state,
  output logic [1:0] scene_sel,
  output logic       scene_change
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GAME  = 2'd2,
    S_SCORE = 2'd3
  } state_t;

  localparam logic [FRAME_CNT_W-1:0] WAIT_LIM  = FRAME_CNT_W'(WAIT_TIMEOUT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] SCORE_LIM = FRAME_CNT_W'(SCORE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_MAX   = '1;

  state_t                 cur;
  state_t                 nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [3:0]             in_q;
  logic [3:0]             in_qq;
  logic [3:0]             rise;
  logic                   tick;
  logic                   play_ev;
  logic                   stop_ev;
  logic                   start_ev;

  // Bit order in the edge pipes: {vblnk, play, stop, uart_start}.
  assign rise     = in_q & ~in_qq;
  assign tick     = rise[3];
  assign play_ev  = rise[2];
  assign stop_ev  = rise[1];
  assign start_ev = rise[0];
  assign state    = cur;

  // Register the level inputs and keep one older copy so only rising edges become events.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      in_q  <= 4'b0;
      in_qq <= 4'b0;
    end else begin
      in_q  <= {vblnk_in, rect_clicked_play, mouse_clicked_stop, uart_start};
      in_qq <= in_q;
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) cur <= S_IDLE;
    else      cur <= nxt;
  end

  // Next-state selection; stop beats uart_start beats timeout while WAITING.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (play_ev) nxt = S_WAIT;
      S_WAIT: begin
        if (stop_ev)                    nxt = S_IDLE;
        else if (start_ev)              nxt = S_GAME;
        else if (frame_cnt == WAIT_LIM) nxt = S_IDLE;
      end
      S_GAME:  if (game_over || stop_ev) nxt = S_SCORE;
      S_SCORE: begin
`ifdef GAME_AUTO_RESTART_EN
        if (stop_ev)                     nxt = S_IDLE;
        else if (frame_cnt == SCORE_LIM) nxt = S_WAIT;
`else
        if (frame_cnt == SCORE_LIM)      nxt = S_IDLE;
`endif
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Frames spent in the current state: restart on any transition, saturate at all-ones.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)                         frame_cnt <= '0;
    else if (nxt != cur)              frame_cnt <= '0;
    else if (tick && frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
  end

  // Scene select only moves on a frame tick, so short-lived states never reach the screen.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      scene_sel    <= 2'd0;
      scene_change <= 1'b0;
    end else if (tick) begin
      scene_sel    <= cur;
      scene_change <= (cur != scene_sel);
    end else begin
      scene_change <= 1'b0;
    end
  end

  // One ready request per WAITING entry; cleared by ack, or when WAITING is left.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)                           uart_tx_req <= 1'b0;
    else if (nxt == S_WAIT && cur != S_WAIT) uart_tx_req <= 1'b1;
    else if (nxt != S_WAIT)             uart_tx_req <= 1'b0;
    else if (uart_tx_ack)               uart_tx_req <= 1'b0;
  end

endmodule

// File: tb/tb_game_state_ctl.sv
// Bench for game_state_ctl: directed scenarios plus a randomized run against a reference model.
// Uses short frame parameters so timeouts are reachable in a few hundred cycles.
// Honours GAME_AUTO_RESTART_EN to pick the expected SCORE-expiry behaviour.
`timescale 1ns/1ps
module tb_game_state_ctl;

  localparam int WT = 4;
  localparam int SF = 3;
  localparam int P_IDLE = 0, P_WAIT = 1, P_GAME = 2, P_SCORE = 3;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk_in = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       ustart = 1'b0;
  logic       game_over = 1'b0;
  logic       ack = 1'b0;
  logic       uart_tx_req;
  logic [1:0] state;
  logic [1:0] scene_sel;
  logic       scene_change;
  logic [5:0] obs;

  int pass_cnt = 0;
  int total = 0;

  // Reference model: phase, frames since entry, displayed scene, pulse, request, input history.
  int m_phase, m_frames, m_scene;
  bit m_chg, m_req;
  bit vb1, vb2, pl1, pl2, sp1, sp2, us1, us2;

  assign obs = {state, scene_sel, scene_change, uart_tx_req};

  game_state_ctl #(.WAIT_TIMEOUT_FRAMES(WT), .SCORE_FRAMES(SF), .FRAME_CNT_W(8)) dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .rect_clicked_play(play),
    .mouse_clicked_stop(stop), .uart_start(ustart), .game_over(game_over),
    .uart_tx_ack(ack), .uart_tx_req(uart_tx_req), .state(state),
    .scene_sel(scene_sel), .scene_change(scene_change)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", total);
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] pk(input int s, input int sc, input bit c, input bit r);
    return {2'(s), 2'(sc), c, r};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b0;
    {vblnk_in, play, stop, ustart, game_over, ack} = 6'b0;
    step(3);
    rst = 1'b1;
  endtask

  // Returns at the negedge of the cycle in which the frame tick is active.
  task automatic vtick();
    vblnk_in = 1'b1;
    step(1);
    vblnk_in = 1'b0;
  endtask

  task automatic model_step(input bit vb, input bit pl, input bit sp, input bit us,
                            input bit go, input bit ak);
    bit t, play_r, stop_r, start_r;
    int np;
    t       = vb1 && !vb2;
    play_r  = pl1 && !pl2;
    stop_r  = sp1 && !sp2;
    start_r = us1 && !us2;
    np = m_phase;
    if (m_phase == P_IDLE) begin
      if (play_r) np = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (stop_r) np = P_IDLE;
      else if (start_r) np = P_GAME;
      else if (m_frames == WT) np = P_IDLE;
    end else if (m_phase == P_GAME) begin
      if (go || stop_r) np = P_SCORE;
    end else begin
`ifdef GAME_AUTO_RESTART_EN
      if (stop_r) np = P_IDLE;
      else if (m_frames == SF) np = P_WAIT;
`else
      if (m_frames == SF) np = P_IDLE;
`endif
    end
    if (np == P_WAIT && m_phase != P_WAIT) m_req = 1'b1;
    else if (np != P_WAIT) m_req = 1'b0;
    else if (ak) m_req = 1'b0;
    if (t) begin
      m_chg   = (m_phase != m_scene);
      m_scene = m_phase;
    end else begin
      m_chg = 1'b0;
    end
    if (np != m_phase) m_frames = 0;
    else if (t && m_frames < 255) m_frames = m_frames + 1;
    m_phase = np;
    vb2 = vb1; vb1 = vb; pl2 = pl1; pl1 = pl;
    sp2 = sp1; sp1 = sp; us2 = us1; us1 = us;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    rst = 1'b0;
    #1;
    total++; if (obs !== 6'b0) $display("FAIL reset_asserted obs=%b exp=%b", obs, 6'b0); else pass_cnt++;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      vtick();
      for (int j = 0; j < 4; j++) begin
        step(1);
        total++; if (obs !== 6'b0) $display("FAIL reset_idle_frames f=%0d obs=%b exp=%b", f, obs, 6'b0); else pass_cnt++;
      end
    end
  endtask

  task automatic test_play_ack();
    do_reset();
    step(2);
    play = 1'b1;
    step(1);
    total++; if (obs !== pk(0,0,0,0)) $display("FAIL play_n1 obs=%b exp=%b", obs, pk(0,0,0,0)); else pass_cnt++;
    step(1);
    total++; if (obs !== pk(1,0,0,1)) $display("FAIL play_n2 obs=%b exp=%b", obs, pk(1,0,0,1)); else pass_cnt++;
    ack = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(1);
      if (j == 2) ack = 1'b0;
      total++; if (obs !== pk(1,0,0,0)) $display("FAIL ack_drop j=%0d obs=%b exp=%b", j, obs, pk(1,0,0,0)); else pass_cnt++;
    end
    vtick();
    total++; if (obs !== pk(1,0,0,0)) $display("FAIL scene_before_load obs=%b exp=%b", obs, pk(1,0,0,0)); else pass_cnt++;
    step(1);
    total++; if (obs !== pk(1,1,1,0)) $display("FAIL scene_load obs=%b exp=%b", obs, pk(1,1,1,0)); else pass_cnt++;
    step(1);
    total++; if (obs !== pk(1,1,0,0)) $display("FAIL scene_pulse_once obs=%b exp=%b", obs, pk(1,1,0,0)); else pass_cnt++;
    vtick();
    step(1);
    total++; if (obs !== pk(1,1,0,0)) $display("FAIL scene_same_no_pulse obs=%b exp=%b", obs, pk(1,1,0,0)); else pass_cnt++;
    play = 1'b0;
  endtask

  task automatic test_stop_vs_start();
    do_reset();
    play = 1'b1;
    step(2);
    total++; if (state !== 2'd1) $display("FAIL svs_enter state=%0d exp=1", state); else pass_cnt++;
    stop = 1'b1;
    ustart = 1'b1;
    step(2);
    total++; if (obs !== pk(0,0,0,0)) $display("FAIL svs_stop_wins obs=%b exp=%b", obs, pk(0,0,0,0)); else pass_cnt++;
    step(5);
    total++; if (state !== 2'd0) $display("FAIL svs_stays_idle state=%0d exp=0", state); else pass_cnt++;
    do_reset();
    play = 1'b1;
    step(2);
    ustart = 1'b1;
    step(2);
    total++; if (obs !== pk(2,0,0,0)) $display("FAIL start_to_game obs=%b exp=%b", obs, pk(2,0,0,0)); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    play = 1'b1;
    step(2);
    total++; if (obs !== pk(1,0,0,1)) $display("FAIL to_enter obs=%b exp=%b", obs, pk(1,0,0,1)); else pass_cnt++;
    for (int f = 0; f < WT - 1; f++) begin
      vtick();
      step(3);
      total++; if (obs !== pk(1,1,0,1)) $display("FAIL to_waiting f=%0d obs=%b exp=%b", f, obs, pk(1,1,0,1)); else pass_cnt++;
    end
    vtick();
    step(1);
    total++; if (obs !== pk(1,1,0,1)) $display("FAIL to_last_tick obs=%b exp=%b", obs, pk(1,1,0,1)); else pass_cnt++;
    step(1);
    total++; if (obs !== pk(0,1,0,0)) $display("FAIL to_expire obs=%b exp=%b", obs, pk(0,1,0,0)); else pass_cnt++;
  endtask

  task automatic test_score();
    int exp_s;
    bit exp_r;
`ifdef GAME_AUTO_RESTART_EN
    exp_s = 1; exp_r = 1'b1;
`else
    exp_s = 0; exp_r = 1'b0;
`endif
    do_reset();
    play = 1'b1;
    step(2);
    ustart = 1'b1;
    step(2);
    total++; if (state !== 2'd2) $display("FAIL sc_game state=%0d exp=2", state); else pass_cnt++;
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    total++; if (state !== 2'd3) $display("FAIL sc_enter state=%0d exp=3", state); else pass_cnt++;
    for (int f = 0; f < SF - 1; f++) begin
      vtick();
      step(2);
      total++; if (state !== 2'd3) $display("FAIL sc_hold f=%0d state=%0d exp=3", f, state); else pass_cnt++;
    end
    vtick();
    step(1);
    total++; if (state !== 2'd3) $display("FAIL sc_last_tick state=%0d exp=3", state); else pass_cnt++;
    step(1);
    total++; if ({state, uart_tx_req} !== {2'(exp_s), exp_r})
      $display("FAIL sc_expire state=%0d req=%0d exp state=%0d req=%0d", state, uart_tx_req, exp_s, exp_r);
    else pass_cnt++;
    // Stop click while in SCORE.
    do_reset();
    play = 1'b1;
    step(2);
    ustart = 1'b1;
    step(2);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    stop = 1'b1;
    step(2);
`ifdef GAME_AUTO_RESTART_EN
    exp_s = 0;
`else
    exp_s = 3;
`endif
    total++; if (state !== 2'(exp_s)) $display("FAIL sc_stop state=%0d exp=%0d", state, exp_s); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    play = 1'b1;
    step(2);
    total++; if (uart_tx_req !== 1'b1) $display("FAIL ar_req_pending req=%0d exp=1", uart_tx_req); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total++; if (obs !== 6'b0) $display("FAIL ar_wait_req obs=%b exp=%b", obs, 6'b0); else pass_cnt++;
    do_reset();
    play = 1'b1;
    step(2);
    vtick();
    step(1);
    ustart = 1'b1;
    step(2);
    vtick();
    step(2);
    total++; if (obs !== pk(2,2,0,0)) $display("FAIL ar_pre_game obs=%b exp=%b", obs, pk(2,2,0,0)); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total++; if (obs !== 6'b0) $display("FAIL ar_game obs=%b exp=%b", obs, 6'b0); else pass_cnt++;
    {vblnk_in, play, stop, ustart, game_over, ack} = 6'b0;
    step(2);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1);
      total++; if (obs !== 6'b0) $display("FAIL ar_after j=%0d obs=%b exp=%b", j, obs, 6'b0); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    m_phase = P_IDLE; m_frames = 0; m_scene = P_IDLE; m_chg = 1'b0; m_req = 1'b0;
    {vb1, vb2, pl1, pl2, sp1, sp2, us1, us2} = 8'b0;
    for (int i = 0; i < 3000; i++) begin
      total++;
      if (obs !== pk(m_phase, m_scene, m_chg, m_req)) begin
        bad++;
        $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, pk(m_phase, m_scene, m_chg, m_req));
      end else pass_cnt++;
      vblnk_in  = vblnk_in ^ ($urandom_range(0, 5) == 0);
      play      = play ^ ($urandom_range(0, 9) == 0);
      stop      = stop ^ ($urandom_range(0, 29) == 0);
      ustart    = ustart ^ ($urandom_range(0, 39) == 0);
      game_over = ($urandom_range(0, 19) == 0);
      ack       = ($urandom_range(0, 3) == 0);
      model_step(vblnk_in, play, stop, ustart, game_over, ack);
      step(1);
    end
    if (bad != 0) $display("random: %0d cycle mismatches", bad);
  endtask

  initial begin
    test_reset();
    test_play_ack();
    test_stop_vs_start();
    test_timeout();
    test_score();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
